subleq_core: RTL and testbench



---
 rtl/subleq_core.sv | 111 +++++++++++
 tb/tb_subleq_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_core.sv
// subleq_core: SUBLEQ instruction sequencer, six bus cycles per instruction.
// Fetches A, B, C at pc..pc+2, reads mem[A] and mem[B], writes mem[B]-mem[A]
// back to B and branches to C when the result is <= 0.
// Width comes from the WORD_SIZE macro (defaults to 16 if not defined).
// Optional feature macro: SUBLEQ_STALL_EN -- retry operand reads from the
// input port while it signals "not available" instead of halting.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module subleq_core (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    halt,
  input  logic [`WORD_SIZE-1:0]   data_in,
  output logic                    load,
  output logic [`WORD_SIZE-1:0]   addr,
  output logic [`WORD_SIZE-1:0]   data_out,
  output logic                    halted,
  output logic [`WORD_SIZE-1:0]   pc
);

  localparam int DATA_W = `WORD_SIZE;

  typedef enum logic [2:0] {
    FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE_B, HALTED
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0]        ra, rb, rc, va, vb;
  logic signed [DATA_W-1:0] diff;
  logic                     taken;
  logic                     stall;

  // Result <= 0 in two's complement: zero or sign bit set.
  function automatic logic branch_taken(input logic signed [DATA_W-1:0] d);
    return (d <= 0);
  endfunction

  assign diff   = signed'(vb - va);
  assign taken  = branch_taken(diff);
  assign halted = (state == HALTED);

`ifdef SUBLEQ_STALL_EN
  localparam logic [DATA_W-1:0] IN_ADDR = {{(DATA_W-1){1'b1}}, 1'b0};
  // A halt while reading the input port means "no word yet": hold and retry.
  assign stall = halt && (((state == READ_A) && (ra == IN_ADDR)) ||
                          ((state == READ_B) && (rb == IN_ADDR)));
`else
  assign stall = 1'b0;
`endif

  // Next-state and bus outputs; reset forces an idle read bus immediately so
  // a WRITE_B cut short by reset never reaches memory.
  always_comb begin
    state_nx = state;
    addr     = '0;
    load     = 1'b1;
    data_out = '0;
    case (state)
      FETCH_A: begin addr = pc;                state_nx = FETCH_B; end
      FETCH_B: begin addr = pc + DATA_W'(1);   state_nx = FETCH_C; end
      FETCH_C: begin addr = pc + DATA_W'(2);   state_nx = READ_A;  end
      READ_A:  begin addr = ra;                state_nx = READ_B;  end
      READ_B:  begin addr = rb;                state_nx = WRITE_B; end
      WRITE_B: begin
        addr     = rb;
        load     = 1'b0;
        data_out = diff;
        state_nx = FETCH_A;
      end
      HALTED:  state_nx = HALTED;
      default: state_nx = HALTED;
    endcase
    if ((state != HALTED) && halt)
      state_nx = stall ? state : HALTED;
    if (!reset_n) begin
      load     = 1'b1;
      addr     = '0;
      data_out = '0;
    end
  end

  // State register and operand latches; a halted cycle latches nothing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= FETCH_A;
      pc    <= '0;
      ra    <= '0;
      rb    <= '0;
      rc    <= '0;
      va    <= '0;
      vb    <= '0;
    end else begin
      state <= state_nx;
      if (!halt) begin
        case (state)
          FETCH_A: ra <= data_in;
          FETCH_B: rb <= data_in;
          FETCH_C: rc <= data_in;
          READ_A:  va <= data_in;
          READ_B:  vb <= data_in;
          WRITE_B: pc <= taken ? rc : pc + DATA_W'(3);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_subleq_core.sv
// tb_subleq_core: directed checks of subleq_core against a small bench-side
// memory/decoder model (input port 0xFFFE, output port 0xFFFD, 0xFFFF halts).
module tb_subleq_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        halt;
  logic [15:0] data_in;
  logic        load;
  logic [15:0] addr;
  logic [15:0] data_out;
  logic        halted;
  logic [15:0] pc;

  int compared = 0;
  int mismatched = 0;

  logic [15:0] mem [0:255];
  logic        clr = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_a = '0;
  logic [15:0] wr_d = '0;
  logic [15:0] in_word = '0;
  int          in_cnt = 0;
  int          pop_cnt = 0;
  int          wcnt = 0;
  int          out_cnt = 0;
  logic [15:0] out_word = '0;
  logic        avail;
  int          w0, o0;

  subleq_core dut (
    .clk(clk), .reset_n(reset_n), .halt(halt), .data_in(data_in),
    .load(load), .addr(addr), .data_out(data_out), .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  assign avail = (in_cnt != pop_cnt);

  always_comb begin
    halt = (addr == 16'hFFFF) || ((addr == 16'hFFFE) && load && !avail);
    if (addr == 16'hFFFE)      data_in = in_word;
    else if (addr >= 16'hFFFD) data_in = 16'h0000;
    else                       data_in = mem[addr[7:0]];
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    end else if (wr_en) begin
      mem[wr_a] <= wr_d;
    end else if (!load) begin
      wcnt <= wcnt + 1;
      if (addr == 16'hFFFD) begin
        out_word <= data_out;
        out_cnt  <= out_cnt + 1;
      end else begin
        mem[addr[7:0]] <= data_out;
      end
    end
    if (load && (addr == 16'hFFFE) && avail && !halt)
      pop_cnt <= pop_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_a = a; wr_d = d;
    cyc(1);
    wr_en = 1'b0;
  endtask

  // Hold reset, clear memory and load a three-word instruction at 0.
  task automatic prog(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    reset_n = 1'b0;
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    poke(8'd0, a);
    poke(8'd1, b);
    poke(8'd2, c);
  endtask

  // Last reset edge, then release: the caller is now sampling cycle 1.
  task automatic start();
    cyc(1);
    reset_n = 1'b1;
  endtask

  initial begin
    // Test 1: {7,7,6}, mem[7]=5 -> write 0 to 7, branch to 6
    prog(16'd7, 16'd7, 16'd6);
    poke(8'd7, 16'd5);
    check("rst_load", {15'd0, load}, 16'd1);
    check("rst_addr", addr, 16'h0000);
    check("rst_dout", data_out, 16'h0000);
    check("rst_pc", pc, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'd0);
    start();
    w0 = wcnt;
    check("t1_c1_addr", addr, 16'h0000);
    check("t1_c1_load", {15'd0, load}, 16'd1);
    cyc(3);
    check("t1_c4_addr", addr, 16'd7);
    cyc(1);
    check("t1_c5_load", {15'd0, load}, 16'd1);
    check("t1_c5_dout", data_out, 16'h0000);
    cyc(1);
    check("t1_c6_load", {15'd0, load}, 16'd0);
    check("t1_c6_addr", addr, 16'd7);
    check("t1_c6_dout", data_out, 16'h0000);
    cyc(1);
    check("t1_c7_pc", pc, 16'd6);
    check("t1_c7_addr", addr, 16'd6);
    check("t1_mem7", mem[7], 16'h0000);
    check("t1_writes", 16'(wcnt - w0), 16'd1);

    // Test 2: 10-3=7, not taken -> pc=3
    prog(16'd8, 16'd9, 16'h0020);
    poke(8'd8, 16'd3);
    poke(8'd9, 16'd10);
    start();
    cyc(5);
    check("t2_dout", data_out, 16'd7);
    cyc(1);
    check("t2_pc", pc, 16'd3);
    check("t2_addr", addr, 16'd3);
    check("t2_mem9", mem[9], 16'd7);

    // Test 3: branch to 0xFFFE; fetch at 0xFFFF halts, pc stays 0xFFFE
    prog(16'h0010, 16'h0010, 16'hFFFE);
    poke(8'h10, 16'd4);
    in_word = 16'h0010;
    in_cnt = pop_cnt + 1;
    start();
    cyc(6);
    check("t3_c7_addr", addr, 16'hFFFE);
    cyc(1);
    check("t3_c8_addr", addr, 16'hFFFF);
    w0 = wcnt;
    cyc(1);
    check("t3_halted", {15'd0, halted}, 16'd1);
    check("t3_addr", addr, 16'h0000);
    check("t3_load", {15'd0, load}, 16'd1);
    check("t3_pc", pc, 16'hFFFE);
    cyc(4);
    check("t3_sticky", {15'd0, halted}, 16'd1);
    check("t3_nowrite", 16'(wcnt - w0), 16'd0);

    // Test 4: input 0x41 -> output 0 - 0x41 = 0xFFBF, taken to 0x30
    prog(16'hFFFE, 16'hFFFD, 16'h0030);
    in_word = 16'h0041;
    in_cnt = pop_cnt + 1;
    o0 = out_cnt;
    start();
    cyc(6);
    check("t4_pc", pc, 16'h0030);
    check("t4_out", out_word, 16'hFFBF);
    check("t4_outcnt", 16'(out_cnt - o0), 16'd1);
    check("t4_halted", {15'd0, halted}, 16'd0);
    check("t4_popped", {15'd0, avail}, 16'd0);

    // Test 5: input unavailable for 3 cycles during READ_A
    prog(16'hFFFE, 16'h0011, 16'h0040);
    poke(8'h11, 16'd2);
    in_word = 16'd5;
    in_cnt = pop_cnt;
    start();
    w0 = wcnt;
    cyc(3);
    check("t5_c4_addr", addr, 16'hFFFE);
    check("t5_c4_halted", {15'd0, halted}, 16'd0);
`ifdef SUBLEQ_STALL_EN
    cyc(2);
    check("t5_c6_addr", addr, 16'hFFFE);
    check("t5_c6_halted", {15'd0, halted}, 16'd0);
    cyc(1);
    in_cnt = pop_cnt + 1;
    cyc(2);
    check("t5_c9_load", {15'd0, load}, 16'd0);
    check("t5_c9_dout", data_out, 16'hFFFD);
    cyc(1);
    check("t5_c10_pc", pc, 16'h0040);
`else
    cyc(1);
    check("t5_halted", {15'd0, halted}, 16'd1);
    check("t5_addr", addr, 16'h0000);
    check("t5_pc", pc, 16'h0000);
    cyc(3);
    check("t5_sticky", {15'd0, halted}, 16'd1);
    check("t5_nowrite", 16'(wcnt - w0), 16'd0);
`endif

    // Test 6: reset asserted during WRITE_B -> no write, clean restart
    prog(16'd8, 16'd9, 16'h0020);
    poke(8'd8, 16'd3);
    poke(8'd9, 16'd10);
    start();
    w0 = wcnt;
    cyc(5);
    reset_n = 1'b0;
    #1;
    check("t6_wb_load", {15'd0, load}, 16'd1);
    cyc(1);
    check("t6_load", {15'd0, load}, 16'd1);
    check("t6_addr", addr, 16'h0000);
    check("t6_pc", pc, 16'h0000);
    check("t6_mem9", mem[9], 16'd10);
    check("t6_nowrite", 16'(wcnt - w0), 16'd0);
    reset_n = 1'b1;
    cyc(3);
    check("t6_restart_addr", addr, 16'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
